// File: rtl/dff_op_sched.sv
// dff_op_sched: two-requester sequencer for a set/reset D flop bank.
// A round-robin arbiter picks one requester; its operation (CLR, SET,
// LOAD, READ) is driven onto the bank control lines for HOLD_CYC cycles.
// The bank output is then read back and verified, and the requester is
// released through a four-phase req/ack handshake.
module dff_op_sched #(
  parameter int WIDTH    = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             ack0,
  output logic             ack1,
  output logic             dff_reset,
  output logic             dff_set,
  output logic [WIDTH-1:0] dff_d,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             grant_id,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
  typedef enum logic [1:0] {OP_CLR = 2'b00, OP_SET = 2'b01,
                            OP_LOAD = 2'b10, OP_READ = 2'b11} op_t;

  // Hold counter is 4 bits wide; HOLD_CYC is limited to 1..15.
  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYC);

  state_t           state_q;
  logic [3:0]       cnt_q;
  op_t              op_q;
  logic [WIDTH-1:0] data_q;
  logic             last_q;
  logic             ack0_q, ack1_q;
  logic             dff_reset_q, dff_set_q;
  logic [WIDTH-1:0] dff_d_q;
  logic [WIDTH-1:0] rdata_q;
  logic             busy_q, grant_id_q, err_q;

  logic             gnt_vld_d;
  logic             gnt_id_d;
  op_t              gnt_op_d;
  logic [WIDTH-1:0] gnt_data_d;
  logic [WIDTH-1:0] exp_d;
  logic             req_gnt_d;

  // Arbitration, granted-request select and expected bank value.
  always_comb begin
    gnt_vld_d = req0 | req1;
    // On a tie the requester not served last wins.
    if (req0 && req1) gnt_id_d = ~last_q;
    else              gnt_id_d = req1;
    gnt_op_d   = gnt_id_d ? op_t'(op1) : op_t'(op0);
    gnt_data_d = gnt_id_d ? d1 : d0;
    req_gnt_d  = grant_id_q ? req1 : req0;
    case (op_q)
      OP_CLR:  exp_d = '0;
      OP_SET:  exp_d = '1;
      default: exp_d = data_q;
    endcase
  end

  // Sequencer FSM with every output registered.
  // NOTE: state is updated with non-blocking assignments so every register
  // in this block samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the reset is synchronous, so it lives inside the clocked
      // branch; the bank is held cleared while reset is low.
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= OP_CLR;
      data_q      <= '0;
      last_q      <= 1'b1;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      dff_reset_q <= 1'b1;
      dff_set_q   <= 1'b0;
      dff_d_q     <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      grant_id_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld_d) begin
            state_q     <= DRIVE;
            busy_q      <= 1'b1;
            grant_id_q  <= gnt_id_d;
            last_q      <= gnt_id_d;
            op_q        <= gnt_op_d;
            data_q      <= gnt_data_d;
            cnt_q       <= HOLD_LD;
            // Control lines go high together with DRIVE entry.
            dff_reset_q <= (gnt_op_d == OP_CLR);
            dff_set_q   <= (gnt_op_d == OP_SET);
            if (gnt_op_d == OP_LOAD) dff_d_q <= gnt_data_d;
          end else begin
            dff_reset_q <= 1'b0;
            dff_set_q   <= 1'b0;
          end
        end
        DRIVE: begin
          if (cnt_q <= 4'd1) begin
            state_q     <= CHECK;
            dff_reset_q <= 1'b0;
            dff_set_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        CHECK: begin
          if (op_q == OP_READ)  rdata_q <= q_in;
          else if (q_in != exp_d) err_q <= 1'b1;
          ack0_q  <= ~grant_id_q & req0;
          ack1_q  <= grant_id_q & req1;
          state_q <= DONE;
        end
        DONE: begin
          // Ack follows the granted req; its release ends the operation.
          if (!req_gnt_d) begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign dff_reset = dff_reset_q;
  assign dff_set   = dff_set_q;
  assign dff_d     = dff_d_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;
  assign err       = err_q;

endmodule

// File: doc/dff_op_sched.md
DFF_OP_SCHED -- requirements
Module: dff_op_sched

Interface
REQ-001 Parameter WIDTH, default 8, width of the controlled set/reset D flip-flop bank.
REQ-002 Parameter HOLD_CYC, default 2, number of cycles the control lines are driven per operation (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 req0, req1  input  1 each  requester 0/1 operation request (level; four-phase handshake).
REQ-006 op0, op1  input  2 each  operation code: 00 CLR, 01 SET, 10 LOAD, 11 READ.
REQ-007 d0, d1  input  WIDTH each  LOAD data for requester 0/1.
REQ-008 ack0, ack1  output  1 each  completion acknowledge to requester 0/1.
REQ-009 dff_reset  output  1  active-high clear to the flop bank.
REQ-010 dff_set  output  1  active-high preset to the flop bank.
REQ-011 dff_d  output  WIDTH  data input to the flop bank.
REQ-012 q_in  input  WIDTH  flop bank outputs.
REQ-013 rdata  output  WIDTH  value captured on the last READ.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 grant_id  output  1  requester currently or most recently served.
REQ-016 err  output  1  sticky verify-mismatch flag.

Function
REQ-017 The FSM shall have four states: IDLE, DRIVE, CHECK, DONE; all outputs shall be registered.
REQ-018 In IDLE, if either req is high, the block shall grant one requester round-robin, latch its op and d, set grant_id, and go to DRIVE next cycle.
REQ-019 Round-robin: when both requests are high, the requester not served last wins; the last-served pointer resets to 1, so req0 wins the first tie.
REQ-020 In DRIVE, for exactly HOLD_CYC cycles: CLR drives dff_reset=1; SET drives dff_set=1; LOAD drives dff_d=latched d; READ drives no control line.
REQ-021 dff_reset and dff_set shall never be high in the same cycle; outside DRIVE both shall be 0.
REQ-022 dff_d shall hold its last LOAD value outside LOAD operations.
REQ-023 CHECK shall last one cycle: READ copies q_in into rdata; otherwise q_in is compared with the expected value (CLR all-0, SET all-1, LOAD latched d), and any mismatch sets err.
REQ-024 err stays 1 until reset; a mismatch shall not abort the operation, and ack is still issued.
REQ-025 In DONE, the granted requester's ack shall be high while its req is high; when that req is sampled low, ack drops and the FSM returns to IDLE in the same edge.
REQ-026 Latency from req sampled high in IDLE to ack high shall be HOLD_CYC+2 cycles (grant, HOLD_CYC DRIVE cycles, CHECK, then ack registered on DONE entry).
REQ-027 The non-granted requester's req shall be ignored until the FSM reaches IDLE; its ack stays 0, and it is granted at the next IDLE evaluation.
REQ-028 Changes on op/d after grant shall have no effect on the operation in flight.
REQ-029 The HOLD_CYC counter shall be sized 4 bits and reload on every grant.

Reset
REQ-030 When reset_n is sampled low, the block shall synchronously force state IDLE, ack0=ack1=0, busy=0, dff_set=0, dff_d=0, rdata=0, err=0, grant_id=0, last-served pointer=1, and dff_reset=1.
REQ-031 dff_reset shall deassert on the first clock edge with reset_n sampled high.
REQ-032 Reset asserted mid-operation shall abort it with no ack; the aborted request is re-arbitrated after reset if req is still high.

Verification
REQ-033 Reset, then req0 with op0=LOAD, d0=8'hA5 and q_in following dff_d → dff_d=8'hA5 for 2 cycles; ack0 high at cycle 4 after req; err=0.
REQ-034 req0 and req1 both high with SET and CLR → req0 served first (dff_set pulse), then req1 (dff_reset pulse); never both control lines high together.
REQ-035 READ with q_in=8'h3C → rdata=8'h3C after CHECK; no control line asserted.
REQ-036 CLR with q_in forced to 8'h01 → err=1 and ack still issued; err stays 1 across later passing operations until reset_n is low.
REQ-037 reset_n low during DRIVE of a SET → dff_set=0 and dff_reset=1 on the next edge, no ack; req held → operation restarts after reset.
REQ-038 req0 held high after ack0 → ack0 stays high and busy=1; req0 dropped → ack0=0 and IDLE on the same edge.
